id_issue: RTL and testbench
===========================

Name: id_issue

Overview:
Parametrised successor to the combinational decode stage. It decodes one MIPS instruction per cycle and resolves operands through a generalised N-port forwarding bus. A per-register load scoreboard replaces the single-cycle load-use check. It drives a registered ID/EX bundle with a valid/ready handshake. Sits between the IF/ID register and EX.

Parameters:
DATA_W, 32, register/operand width
REG_NUM, 32, architectural registers; address width is clog2(REG_NUM)
FWD_PORTS, 2, forwarding sources; index 0 = youngest (EX), highest priority
LOAD_LAT, 2, cycles a load destination stays non-forwardable after issue, counted in cycles with ex_ready_i=1; range 1..7

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid_i  in  1  pc_i/inst_i hold a valid instruction
if_ready_o  out  1  instruction accepted this cycle when high with if_valid_i
pc_i  in  32  instruction address
inst_i  in  32  instruction word
reg1_addr_o / reg2_addr_o  out  AW each  regfile read addresses, combinational from inst_i[25:21] / inst_i[20:16]
reg1_data_i / reg2_data_i  in  DATA_W each  regfile read data, same cycle
fwd_wreg_i  in  FWD_PORTS  forwarding write enables
fwd_wd_i  in  AW*FWD_PORTS  forwarding destinations, flattened
fwd_wdata_i  in  DATA_W*FWD_PORTS  forwarding data, flattened
ex_valid_o  out  1  ID/EX bundle valid
ex_ready_i  in  1  EX accepts the bundle
aluop_o, alusel_o  out  `AluOpBus/`AluSelBus  registered operation
reg1_o, reg2_o  out  DATA_W each  registered resolved operands; the immediate goes on reg2_o
wd_o, wreg_o  out  AW/1  registered destination and write enable
pc_o, inst_o  out  32 each  registered pc and instruction
branch_flag_o  out  1  one-cycle pulse, cycle after a taken branch/jump issues
branch_target_address_o  out  32  valid while branch_flag_o=1, else 0

Behaviour:
- Reset: every registered output is 0. aluop/alusel take the NOP codes. Scoreboard is cleared. if_ready_o=0 during reset. Reset mid-operation discards the held bundle and all pending loads.
- Decoded ops: OR, AND, SLT, ADD, SUB (SPECIAL, shamt=0); J, BEQ, BNE, LW, SW; new ORI (zero-ext), ADDI (sign-ext), LUI ({imm,16'h0}). Unknown opcode issues as NOP with wreg_o=0.
- Operand resolution per source, in priority order:
  - addr 0 gives 0;
  - the lowest-index fwd port with wreg=1 and a matching wd gives its data;
  - otherwise regfile data.
  - A non-read source gives 0 (rs) or the immediate (rt slot).
- Stall: stall=1 when a read source addr≠0 has scoreboard count≠0.
- if_ready_o = !rst && !stall && (!ex_valid_o || ex_ready_i). Issue = if_valid_i && if_ready_o.
- Output register:
  - on issue, load the bundle and set ex_valid_o=1;
  - else if ex_ready_i, set ex_valid_o=0;
  - else hold (all outputs stable while ex_valid_o=1 and ex_ready_i=0).
- Scoreboard: one count per register, 3 bits.
  - When ex_ready_i=1, every nonzero count decrements.
  - Issuing LW with rt≠0 sets count[rt]=LOAD_LAT; this write overrides the decrement for that register.
  - LW writing to r0 never marks the scoreboard.
- Branches are evaluated at issue on resolved operands: BEQ taken if equal, BNE if unequal, J always.
  - BEQ/BNE target = pc+4+(sext(imm)<<2); J target = {pc+4[31:28], idx, 2'b00}.
  - Delay slot executes; no flush.
  - branch_flag_o pulses exactly one cycle even if EX back-pressures.
- A stalled branch does not pulse until it issues.
- LW writes rt; SW/branches/J have wreg_o=0.
- Latency: 1 cycle from issue to ex_valid_o.

Optional Feature:
Macro ID_PERF_CNT_EN.
- When defined: adds outputs perf_issue_o[31:0] and perf_stall_o[31:0].
  - perf_issue_o increments on each issue.
  - perf_stall_o increments each cycle with if_valid_i=1 && stall=1.
  - Both wrap at 2^32 and clear on reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Opcodes, funct codes, aluop/alusel codes, and the new EXE_ORI/ADDI/LUI/BNE codes go in the shared defines.v.
- One sub-module, id_scoreboard: per-register load counters with set/decrement/query ports (two query addresses, one set address, advance enable).
- Decode and forwarding muxes stay in id_issue.

Test Plan:
- Reset, then if_valid_i=1 with ADD r3,r1,r2 and regfile 5/7 -> after 1 cycle ex_valid_o=1, reg1_o=5, reg2_o=7, wd_o=3, wreg_o=1.
- fwd port0 (r1=0xAA) and port1 (r1=0xBB) both valid while issuing OR r4,r1,r0 -> reg1_o=0xAA, reg2_o=0.
- LW r5 issued, next instruction ADD r6,r5,r5 with LOAD_LAT=2 and ex_ready_i=1 -> if_ready_o=0 for 2 cycles, then issue; with ex_ready_i=0 the stall holds indefinitely.
- BEQ r1,r2,offset 4 at pc 0x100 with r1=r2 -> branch_flag_o pulses 1 cycle with target 0x114; BNE with the same operands -> no pulse.
- ex_ready_i=0 while the bundle is valid -> all outputs stable and if_ready_o=0; assert rst mid-hold -> next cycle ex_valid_o=0 and the scoreboard is clear.
- ID_PERF_CNT_EN build: 3 issues and 2 stall cycles -> perf_issue_o=3, perf_stall_o=2.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared decode constants for id_issue: MIPS opcodes/funct codes plus the
// aluop/alusel encodings carried on the ID/EX bundle.
package id_issue_pkg;

  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_J       = 6'b000010;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_BNE     = 6'b000101;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_SW      = 6'b101011;

  localparam logic [5:0] EXE_FN_ADD  = 6'b100000;
  localparam logic [5:0] EXE_FN_SUB  = 6'b100010;
  localparam logic [5:0] EXE_FN_AND  = 6'b100100;
  localparam logic [5:0] EXE_FN_OR   = 6'b100101;
  localparam logic [5:0] EXE_FN_SLT  = 6'b101010;

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_ADD = 8'h20,
    ALU_SUB = 8'h22,
    ALU_AND = 8'h24,
    ALU_OR  = 8'h25,
    ALU_SLT = 8'h2a,
    ALU_J   = 8'h4f,
    ALU_BEQ = 8'h51,
    ALU_BNE = 8'h52,
    ALU_LW  = 8'he3,
    ALU_SW  = 8'heb
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP       = 3'b000,
    SEL_LOGIC     = 3'b001,
    SEL_ARITH     = 3'b100,
    SEL_JUMP      = 3'b110,
    SEL_LOADSTORE = 3'b111
  } alusel_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_J,
    BR_BEQ,
    BR_BNE
  } branch_e;

endpackage

// File: rtl/id_scoreboard.sv
// Per-register load scoreboard: a count per register, set on load issue and
// decremented each cycle EX advances; register 0 is never marked.
module id_scoreboard #(
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy
);

  logic [2:0] cnt [REG_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        // A fresh load on the same register wins over this cycle's decrement.
        if (set_en && i != 0 && set_addr == AW'(i))
          cnt[i] <= 3'(LOAD_LAT);
        else if (advance && cnt[i] != '0)
          cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  assign q1_busy = (cnt[q1_addr] != '0);
  assign q2_busy = (cnt[q2_addr] != '0);

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: decodes, forwards, checks the load scoreboard, and drives
// a registered ID/EX bundle. ID_PERF_CNT_EN adds issue/stall counters.
module id_issue
  import id_issue_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned FWD_PORTS = 2,
  parameter int unsigned LOAD_LAT  = 2,
  localparam int unsigned AW = $clog2(REG_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_valid_i,
  output logic                        if_ready_o,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 inst_i,
  output logic [AW-1:0]               reg1_addr_o,
  output logic [AW-1:0]               reg2_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [FWD_PORTS-1:0]        fwd_wreg_i,
  input  logic [AW*FWD_PORTS-1:0]     fwd_wd_i,
  input  logic [DATA_W*FWD_PORTS-1:0] fwd_wdata_i,
  output logic                        ex_valid_o,
  input  logic                        ex_ready_i,
  output logic [7:0]                  aluop_o,
  output logic [2:0]                  alusel_o,
  output logic [DATA_W-1:0]           reg1_o,
  output logic [DATA_W-1:0]           reg2_o,
  output logic [AW-1:0]               wd_o,
  output logic                        wreg_o,
  output logic [31:0]                 pc_o,
  output logic [31:0]                 inst_o,
  output logic                        branch_flag_o,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]                 perf_issue_o,
  output logic [31:0]                 perf_stall_o,
`endif
  output logic [31:0]                 branch_target_address_o
);

  logic [5:0]        op, funct;
  logic [4:0]        shamt;
  logic [AW-1:0]     rs, rt, rd;
  aluop_e            dec_aluop;
  alusel_e           dec_alusel;
  branch_e           br;
  logic              re1, re2, dec_wreg, is_lw;
  logic [AW-1:0]     dec_wd;
  logic [DATA_W-1:0] imm, src1, src2, fwd1_data, fwd2_data;
  logic              fwd1_hit, fwd2_hit, busy1, busy2, stall, issue, taken;
  logic [31:0]       pc4, target;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign shamt = inst_i[10:6];
  assign rs    = AW'(inst_i[25:21]);
  assign rt    = AW'(inst_i[20:16]);
  assign rd    = AW'(inst_i[15:11]);

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  always_comb begin
    dec_aluop  = ALU_NOP;
    dec_alusel = SEL_NOP;
    re1        = 1'b0;
    re2        = 1'b0;
    dec_wreg   = 1'b0;
    dec_wd     = '0;
    imm        = '0;
    br         = BR_NONE;
    is_lw      = 1'b0;
    case (op)
      EXE_SPECIAL: begin
        if (shamt == 5'd0) begin
          case (funct)
            EXE_FN_OR:  begin dec_aluop = ALU_OR;  dec_alusel = SEL_LOGIC; end
            EXE_FN_AND: begin dec_aluop = ALU_AND; dec_alusel = SEL_LOGIC; end
            EXE_FN_SLT: begin dec_aluop = ALU_SLT; dec_alusel = SEL_ARITH; end
            EXE_FN_ADD: begin dec_aluop = ALU_ADD; dec_alusel = SEL_ARITH; end
            EXE_FN_SUB: begin dec_aluop = ALU_SUB; dec_alusel = SEL_ARITH; end
            default: ;
          endcase
          if (dec_aluop != ALU_NOP) begin
            re1 = 1'b1; re2 = 1'b1; dec_wreg = 1'b1; dec_wd = rd;
          end
        end
      end
      EXE_ORI: begin
        dec_aluop = ALU_OR; dec_alusel = SEL_LOGIC;
        re1 = 1'b1; dec_wreg = 1'b1; dec_wd = rt;
        imm = DATA_W'(inst_i[15:0]);
      end
      EXE_ADDI: begin
        dec_aluop = ALU_ADD; dec_alusel = SEL_ARITH;
        re1 = 1'b1; dec_wreg = 1'b1; dec_wd = rt;
        imm = DATA_W'($signed(inst_i[15:0]));
      end
      EXE_LUI: begin
        dec_aluop = ALU_OR; dec_alusel = SEL_LOGIC;
        dec_wreg = 1'b1; dec_wd = rt;
        imm = DATA_W'({inst_i[15:0], 16'h0000});
      end
      EXE_LW: begin
        dec_aluop = ALU_LW; dec_alusel = SEL_LOADSTORE;
        re1 = 1'b1; dec_wreg = 1'b1; dec_wd = rt; is_lw = 1'b1;
        imm = DATA_W'($signed(inst_i[15:0]));
      end
      EXE_SW: begin
        dec_aluop = ALU_SW; dec_alusel = SEL_LOADSTORE;
        re1 = 1'b1; re2 = 1'b1;
      end
      EXE_BEQ: begin
        dec_aluop = ALU_BEQ; dec_alusel = SEL_JUMP;
        re1 = 1'b1; re2 = 1'b1; br = BR_BEQ;
      end
      EXE_BNE: begin
        dec_aluop = ALU_BNE; dec_alusel = SEL_JUMP;
        re1 = 1'b1; re2 = 1'b1; br = BR_BNE;
      end
      EXE_J: begin
        dec_aluop = ALU_J; dec_alusel = SEL_JUMP; br = BR_J;
      end
      default: ;
    endcase
  end

  // Walk ports from oldest to youngest so the lowest index ends up winning.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int unsigned i = 0; i < FWD_PORTS; i++) begin
      if (fwd_wreg_i[FWD_PORTS-1-i] && fwd_wd_i[(FWD_PORTS-1-i)*AW +: AW] == rs) begin
        fwd1_hit  = 1'b1;
        fwd1_data = fwd_wdata_i[(FWD_PORTS-1-i)*DATA_W +: DATA_W];
      end
      if (fwd_wreg_i[FWD_PORTS-1-i] && fwd_wd_i[(FWD_PORTS-1-i)*AW +: AW] == rt) begin
        fwd2_hit  = 1'b1;
        fwd2_data = fwd_wdata_i[(FWD_PORTS-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  assign src1 = !re1 ? '0 : (rs == '0) ? '0 : fwd1_hit ? fwd1_data : reg1_data_i;
  assign src2 = !re2 ? imm : (rt == '0) ? '0 : fwd2_hit ? fwd2_data : reg2_data_i;

  id_scoreboard #(
    .REG_NUM  (REG_NUM),
    .AW       (AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .advance  (ex_ready_i),
    .set_en   (issue && is_lw),
    .set_addr (rt),
    .q1_addr  (rs),
    .q2_addr  (rt),
    .q1_busy  (busy1),
    .q2_busy  (busy2)
  );

  assign stall      = (re1 && rs != '0 && busy1) || (re2 && rt != '0 && busy2);
  assign if_ready_o = !rst && !stall && (!ex_valid_o || ex_ready_i);
  assign issue      = if_valid_i && if_ready_o;

  assign pc4    = pc_i + 32'd4;
  assign taken  = (br == BR_J) || (br == BR_BEQ && src1 == src2) || (br == BR_BNE && src1 != src2);
  assign target = (br == BR_J) ? {pc4[31:28], inst_i[25:0], 2'b00}
                               : pc4 + {{14{inst_i[15]}}, inst_i[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_o              <= 1'b0;
      aluop_o                 <= ALU_NOP;
      alusel_o                <= SEL_NOP;
      reg1_o                  <= '0;
      reg2_o                  <= '0;
      wd_o                    <= '0;
      wreg_o                  <= 1'b0;
      pc_o                    <= '0;
      inst_o                  <= '0;
      branch_flag_o           <= 1'b0;
      branch_target_address_o <= '0;
    end else begin
      branch_flag_o           <= issue && taken;
      branch_target_address_o <= (issue && taken) ? target : '0;
      if (issue) begin
        ex_valid_o <= 1'b1;
        aluop_o    <= dec_aluop;
        alusel_o   <= dec_alusel;
        reg1_o     <= src1;
        reg2_o     <= src2;
        wd_o       <= dec_wd;
        wreg_o     <= dec_wreg;
        pc_o       <= pc_i;
        inst_o     <= inst_i;
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (issue)               perf_issue_o <= perf_issue_o + 32'd1;
      if (if_valid_i && stall) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_issue.sv
// Bench for id_issue: mnemonic-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_id_issue;
  localparam int DW = 32, NREG = 32, FWD = 2, LL = 2, AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, if_valid_i, if_ready_o, ex_valid_o, ex_ready_i, wreg_o, branch_flag_o;
  logic [31:0] pc_i, inst_i, pc_o, inst_o, branch_target_address_o;
  logic [AW-1:0] reg1_addr_o, reg2_addr_o, wd_o;
  logic [DW-1:0] reg1_data_i, reg2_data_i, reg1_o, reg2_o;
  logic [FWD-1:0] fwd_wreg_i;
  logic [AW*FWD-1:0] fwd_wd_i;
  logic [DW*FWD-1:0] fwd_wdata_i;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_issue_o, perf_stall_o;
`endif

  logic [DW-1:0] rf [NREG];
  logic          fwd_we   [FWD];
  logic [AW-1:0] fwd_addr [FWD];
  logic [DW-1:0] fwd_dat  [FWD];

  for (genvar p = 0; p < FWD; p++) begin : g_fwd
    assign fwd_wreg_i[p]             = fwd_we[p];
    assign fwd_wd_i[p*AW +: AW]      = fwd_addr[p];
    assign fwd_wdata_i[p*DW +: DW]   = fwd_dat[p];
  end
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_issue #(.DATA_W(DW), .REG_NUM(NREG), .FWD_PORTS(FWD), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o),
    .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_o(inst_o),
    .branch_flag_o(branch_flag_o),
`ifdef ID_PERF_CNT_EN
    .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o),
`endif
    .branch_target_address_o(branch_target_address_o)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        rs_rd, rt_rd, wr;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [7:0]  aluop;
    logic [2:0]  sel;
    logic [1:0]  br;   // 0 none, 1 J, 2 BEQ, 3 BNE
  } prop_t;

  function automatic string mnem(input logic [31:0] w);
    case (w[31:26])
      6'h00: begin
        if (w[10:6] != 5'd0) return "NOP";
        case (w[5:0])
          6'h20: return "ADD";
          6'h22: return "SUB";
          6'h24: return "AND";
          6'h25: return "OR";
          6'h2a: return "SLT";
          default: return "NOP";
        endcase
      end
      6'h02: return "J";
      6'h04: return "BEQ";
      6'h05: return "BNE";
      6'h08: return "ADDI";
      6'h0d: return "ORI";
      6'h0f: return "LUI";
      6'h23: return "LW";
      6'h2b: return "SW";
      default: return "NOP";
    endcase
  endfunction

  function automatic prop_t props(input logic [31:0] w);
    prop_t p;
    string m;
    logic [31:0] se;
    m  = mnem(w);
    se = {{16{w[15]}}, w[15:0]};
    p  = '0;
    if (m == "ADD" || m == "SUB" || m == "AND" || m == "OR" || m == "SLT") begin
      p.rs_rd = 1; p.rt_rd = 1; p.wr = 1; p.dest = w[15:11];
    end
    if (m == "ORI" || m == "ADDI" || m == "LW" || m == "LUI") begin
      p.wr = 1; p.dest = w[20:16]; p.rs_rd = (m != "LUI");
    end
    if (m == "BEQ" || m == "BNE" || m == "SW") begin p.rs_rd = 1; p.rt_rd = 1; end
    if (m == "ORI") p.imm = {16'h0, w[15:0]};
    if (m == "LUI") p.imm = {w[15:0], 16'h0};
    if (m == "ADDI" || m == "LW") p.imm = se;
    if (m == "ADD" || m == "ADDI") begin p.aluop = 8'h20; p.sel = 3'd4; end
    if (m == "SUB") begin p.aluop = 8'h22; p.sel = 3'd4; end
    if (m == "SLT") begin p.aluop = 8'h2a; p.sel = 3'd4; end
    if (m == "AND") begin p.aluop = 8'h24; p.sel = 3'd1; end
    if (m == "OR" || m == "ORI" || m == "LUI") begin p.aluop = 8'h25; p.sel = 3'd1; end
    if (m == "LW") begin p.aluop = 8'he3; p.sel = 3'd7; end
    if (m == "SW") begin p.aluop = 8'heb; p.sel = 3'd7; end
    if (m == "J")   begin p.aluop = 8'h4f; p.sel = 3'd6; p.br = 2'd1; end
    if (m == "BEQ") begin p.aluop = 8'h51; p.sel = 3'd6; p.br = 2'd2; end
    if (m == "BNE") begin p.aluop = 8'h52; p.sel = 3'd6; p.br = 2'd3; end
    return p;
  endfunction

  int          sb [NREG];
  logic        m_valid, m_wreg, m_bf;
  logic [7:0]  m_aluop;
  logic [2:0]  m_sel;
  logic [31:0] m_r1, m_r2, m_pc, m_inst, m_bt, m_pi, m_ps;
  logic [4:0]  m_wd;

  function automatic logic [31:0] resolve(input logic [4:0] a);
    if (a == 0) return 32'd0;
    for (int p = 0; p < FWD; p++)
      if (fwd_we[p] && fwd_addr[p] == a) return fwd_dat[p];
    return rf[a];
  endfunction

  function automatic bit m_stall();
    prop_t p;
    p = props(inst_i);
    return (p.rs_rd && inst_i[25:21] != 0 && sb[inst_i[25:21]] != 0) ||
           (p.rt_rd && inst_i[20:16] != 0 && sb[inst_i[20:16]] != 0);
  endfunction

  function automatic bit m_ready();
    return !rst && !m_stall() && (!m_valid || ex_ready_i);
  endfunction

  always @(posedge clk) begin
    prop_t p;
    logic [31:0] a, b, pc4, tgt;
    bit st, iss, tk;
    if (rst) begin
      m_valid = 0; m_aluop = 0; m_sel = 0; m_r1 = 0; m_r2 = 0; m_wd = 0; m_wreg = 0;
      m_pc = 0; m_inst = 0; m_bf = 0; m_bt = 0; m_pi = 0; m_ps = 0;
      for (int r = 0; r < NREG; r++) sb[r] = 0;
    end else begin
      p   = props(inst_i);
      st  = m_stall();
      iss = if_valid_i && !st && (!m_valid || ex_ready_i);
      if (if_valid_i && st) m_ps = m_ps + 1;
      if (iss) m_pi = m_pi + 1;
      a   = p.rs_rd ? resolve(inst_i[25:21]) : 32'd0;
      b   = p.rt_rd ? resolve(inst_i[20:16]) : p.imm;
      pc4 = pc_i + 4;
      tk  = (p.br == 1) || (p.br == 2 && a == b) || (p.br == 3 && a != b);
      tgt = (p.br == 1) ? {pc4[31:28], inst_i[25:0], 2'b00}
                        : pc4 + ({{16{inst_i[15]}}, inst_i[15:0]} << 2);
      m_bf = iss && tk;
      m_bt = (iss && tk) ? tgt : 32'd0;
      if (ex_ready_i)
        for (int r = 0; r < NREG; r++) if (sb[r] > 0) sb[r] = sb[r] - 1;
      if (iss && mnem(inst_i) == "LW" && inst_i[20:16] != 0) sb[inst_i[20:16]] = LL;
      if (iss) begin
        m_valid = 1; m_aluop = p.aluop; m_sel = p.sel; m_r1 = a; m_r2 = b;
        m_wd = p.wr ? p.dest : 5'd0; m_wreg = p.wr; m_pc = pc_i; m_inst = inst_i;
      end else if (ex_ready_i) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("if_ready", if_ready_o, m_ready());
    chk("reg1_addr", reg1_addr_o, inst_i[25:21]);
    chk("reg2_addr", reg2_addr_o, inst_i[20:16]);
    chk("ex_valid", ex_valid_o, m_valid);
    if (m_valid) begin
      chk("aluop", aluop_o, m_aluop);
      chk("alusel", alusel_o, m_sel);
      chk("reg1", reg1_o, m_r1);
      chk("reg2", reg2_o, m_r2);
      chk("wd", wd_o, m_wd);
      chk("wreg", wreg_o, m_wreg);
      chk("pc", pc_o, m_pc);
      chk("inst", inst_o, m_inst);
    end
    chk("branch_flag", branch_flag_o, m_bf);
    chk("branch_target", branch_target_address_o, m_bt);
`ifdef ID_PERF_CNT_EN
    chk("perf_issue", perf_issue_o, m_pi);
    chk("perf_stall", perf_stall_o, m_ps);
`endif
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic fwd_off();
    for (int p = 0; p < FWD; p++) begin fwd_we[p] = 0; fwd_addr[p] = 0; fwd_dat[p] = 0; end
  endtask

  logic [31:0] tab [14];
  bit ok;
  int pat = 0;

  initial begin
    rst = 1; if_valid_i = 0; ex_ready_i = 1; pc_i = 0; inst_i = 0;
    fwd_off();
    for (int r = 0; r < NREG; r++) rf[r] = 32'h1000 + r;
    rf[1] = 5; rf[2] = 7;
    cyc(); cyc();
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_if_ready", if_ready_o, 0);
    chk("rst_aluop", aluop_o, 0);
    chk("rst_reg1", reg1_o, 0);

    rst = 0; if_valid_i = 1; inst_i = rtype(1, 2, 3, 6'h20); pc_i = 0;
    cyc();
    chk("add_valid", ex_valid_o, 1);
    chk("add_reg1", reg1_o, 5);
    chk("add_reg2", reg2_o, 7);
    chk("add_wd", wd_o, 3);
    chk("add_wreg", wreg_o, 1);

    inst_i = rtype(1, 0, 4, 6'h25); pc_i = 4;
    fwd_we[0] = 1; fwd_addr[0] = 1; fwd_dat[0] = 32'hAA;
    fwd_we[1] = 1; fwd_addr[1] = 1; fwd_dat[1] = 32'hBB;
    cyc();
    chk("fwd_prio_reg1", reg1_o, 32'hAA);
    chk("fwd_r0_reg2", reg2_o, 0);

    fwd_off();
    inst_i = itype(6'h23, 1, 5, 16'h0); pc_i = 8;
    cyc();
    chk("lw_wd", wd_o, 5);
    inst_i = rtype(5, 5, 6, 6'h20); pc_i = 12;
    #1 chk("lu_stall0", if_ready_o, 0);
    cyc();
    chk("lu_stall1", if_ready_o, 0);
    chk("lu_drained", ex_valid_o, 0);
    cyc();
    chk("lu_release", if_ready_o, 1);
`ifdef ID_PERF_CNT_EN
    chk("perf_issue3", perf_issue_o, 3);
    chk("perf_stall2", perf_stall_o, 2);
`endif
    cyc();
    chk("lu_issue_wd", wd_o, 6);
    chk("lu_issue_reg1", reg1_o, 32'h1005);

    // hold with a pending load, then reset mid-hold
    inst_i = itype(6'h23, 2, 7, 16'h0); pc_i = 16;
    cyc();
    ex_ready_i = 0; inst_i = rtype(7, 0, 8, 6'h20); pc_i = 20;
    cyc(); cyc(); cyc();
    chk("hold_if_ready", if_ready_o, 0);
    chk("hold_valid", ex_valid_o, 1);
    chk("hold_wd", wd_o, 7);
    rst = 1;
    cyc();
    chk("rst_hold_valid", ex_valid_o, 0);
    rst = 0; ex_ready_i = 1;
    #1 chk("sb_cleared", if_ready_o, 1);
    cyc();
    chk("post_rst_wd", wd_o, 8);

    // branches
    rf[2] = 5; pc_i = 32'h100; inst_i = itype(6'h04, 1, 2, 16'd4);
    cyc();
    chk("beq_flag", branch_flag_o, 1);
    chk("beq_target", branch_target_address_o, 32'h114);
    if_valid_i = 0;
    cyc();
    chk("beq_pulse_end", branch_flag_o, 0);
    chk("beq_target_clr", branch_target_address_o, 0);
    if_valid_i = 1; inst_i = itype(6'h05, 1, 2, 16'd4);
    cyc();
    chk("bne_no_flag", branch_flag_o, 0);
    pc_i = 32'h1000_0200; inst_i = {6'h02, 26'h40};
    cyc();
    chk("j_flag", branch_flag_o, 1);
    chk("j_target", branch_target_address_o, 32'h1000_0100);
    rf[2] = 7;

    // immediates and unknown opcode
    pc_i = 32'h180; inst_i = itype(6'h0d, 1, 10, 16'h8001);
    cyc();
    chk("ori_reg2", reg2_o, 32'h0000_8001);
    chk("ori_reg1", reg1_o, 5);
    inst_i = itype(6'h08, 1, 11, 16'hFFFD);
    cyc();
    chk("addi_reg2", reg2_o, 32'hFFFF_FFFD);
    inst_i = itype(6'h0f, 0, 12, 16'h1234);
    cyc();
    chk("lui_reg2", reg2_o, 32'h1234_0000);
    inst_i = 32'hFFFF_FFFF;
    cyc();
    chk("unk_wreg", wreg_o, 0);
    chk("unk_aluop", aluop_o, 0);
    inst_i = itype(6'h23, 1, 0, 16'h0);
    cyc();
    inst_i = rtype(0, 0, 15, 6'h20);
    #1 chk("lw_r0_no_mark", if_ready_o, 1);
    cyc();

    // mixed table with back-pressure and forwarding
    tab[0]  = rtype(1, 2, 13, 6'h22);
    tab[1]  = rtype(1, 3, 14, 6'h24);
    tab[2]  = rtype(2, 1, 16, 6'h2a);
    tab[3]  = itype(6'h23, 1, 9, 16'd4);
    tab[4]  = itype(6'h04, 9, 9, 16'd8);
    tab[5]  = itype(6'h05, 1, 2, 16'hFFFE);
    tab[6]  = itype(6'h2b, 1, 2, 16'd8);
    tab[7]  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd1, 6'h20};
    tab[8]  = rtype(3, 4, 17, 6'h25);
    tab[9]  = itype(6'h08, 9, 18, 16'd1);
    tab[10] = itype(6'h23, 0, 3, 16'h0);
    tab[11] = rtype(3, 1, 19, 6'h20);
    tab[12] = {6'h02, 26'h123};
    tab[13] = rtype(1, 2, 20, 6'h2a);
    for (int i = 0; i < 14; i++) begin
      inst_i = tab[i]; pc_i = 32'h200 + 4 * i;
      fwd_off();
      if (i % 3 == 1) begin fwd_we[0] = 1; fwd_addr[0] = 1; fwd_dat[0] = 32'hF00 + i; end
      if (i % 2 == 0) begin fwd_we[1] = 1; fwd_addr[1] = 3; fwd_dat[1] = 32'hE00 + i; end
      ok = 0;
      for (int k = 0; k < 20; k++) begin
        ex_ready_i = (pat % 3) != 2;
        pat++;
        #1 ok = if_ready_o;
        cyc();
        if (ok) break;
      end
      if (!ok) chk("issue_timeout", 0, 1);
    end
    if_valid_i = 0; ex_ready_i = 1; fwd_off();
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
